// File: rtl/mayur_wallace_pkg.sv
// Shared helpers for the pipelined Wallace-tree multiplier: reduction-depth arithmetic
// and the default product width.
package mayur_wallace_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int PROD_W        = 2 * WIDTH_DEFAULT;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // One 3:2 level turns every full group of three rows into two; leftovers pass through.
  function automatic int rows_after_level(input int rows);
    return 2 * (rows / 3) + (rows % 3);
  endfunction

  function automatic int rows_at_level(input int rows, input int level);
    int r;
    r = rows;
    for (int i = 0; i < level; i++) r = rows_after_level(r);
    return r;
  endfunction

  function automatic int wallace_levels(input int rows);
    int r;
    int n;
    r = rows;
    n = 0;
    while (r > 2) begin
      r = rows_after_level(r);
      n++;
    end
    return n;
  endfunction

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mayur_wallace_csa_level.sv
// One combinational Wallace reduction level: groups of three rows go through carry-save
// full adders (sum row + shifted carry row); remaining rows pass straight through.
module mayur_wallace_csa_level #(
  parameter int ROWS_IN  = 3,
  parameter int ROWS_OUT = 2,
  parameter int ROW_W    = 16
) (
  input  logic [ROWS_IN-1:0][ROW_W-1:0]  rows_in,
  output logic [ROWS_OUT-1:0][ROW_W-1:0] rows_out
);

  localparam int GROUPS = ROWS_IN / 3;
  localparam int SPARE  = ROWS_IN % 3;

  for (genvar g = 0; g < GROUPS; g++) begin : g_fa
    assign rows_out[2*g]   = rows_in[3*g] ^ rows_in[3*g+1] ^ rows_in[3*g+2];
    // Carry out of column k lands in column k+1; the top carry is dropped (mod 2^ROW_W).
    assign rows_out[2*g+1] = ((rows_in[3*g] & rows_in[3*g+1]) |
                              (rows_in[3*g] & rows_in[3*g+2]) |
                              (rows_in[3*g+1] & rows_in[3*g+2])) << 1;
  end

  for (genvar s = 0; s < SPARE; s++) begin : g_pass
    assign rows_out[2*GROUPS+s] = rows_in[3*GROUPS+s];
  end

endmodule

// File: rtl/mayur_wallace_pipe.sv
// Three-stage WIDTH x WIDTH Wallace multiplier with valid/ready on both sides.
// Optional macro WALLACE_PIPE_MAC_EN adds Data_in_Acc (accumulate into previous product).
module mayur_wallace_pipe
  import mayur_wallace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Data_in_Valid,
  output logic               Data_in_Ready,
  input  logic [WIDTH-1:0]   Data_in_A,
  input  logic [WIDTH-1:0]   Data_in_B,
  input  logic               Data_in_Signed,
  input  logic [TAG_W-1:0]   Data_in_Tag,
`ifdef WALLACE_PIPE_MAC_EN
  input  logic               Data_in_Acc,
`endif
  output logic               Data_out_Valid,
  input  logic               Data_out_Ready,
  output logic [2*WIDTH-1:0] Data_out_Prod,
  output logic [TAG_W-1:0]   Data_out_Tag
);

  localparam int N      = WIDTH + 1;
  localparam int PW     = prod_width(WIDTH);
  localparam int NROWS  = N + 1;
  localparam int LEVELS = wallace_levels(NROWS);

  logic v1, v2, v3;
  logic ready2, ready3;

  assign ready3         = !v3 || Data_out_Ready;
  assign ready2         = !v2 || ready3;
  assign Data_in_Ready  = !v1 || ready2;
  assign Data_out_Valid = v3;

  logic [WIDTH:0]           a_ext, b_ext;
  logic [N-1:0][N-1:0]      pp_d, pp_q;
  logic [TAG_W-1:0]         tag1, tag2, tag3;
  logic [NROWS-1:0][PW-1:0] rows0;
  logic [PW-1:0]            red_a, red_b, row_a_q, row_b_q;
  logic [PW-1:0]            s3_sum, s3_d, prod_q;
  logic                     unused_pp_msb;

  // Unsigned operands get a zero top bit, so one signed partial-product scheme covers both modes.
  assign a_ext = {Data_in_Signed & Data_in_A[WIDTH-1], Data_in_A};
  assign b_ext = {Data_in_Signed & Data_in_B[WIDTH-1], Data_in_B};

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        pp_d[i][j] = a_ext[j] & b_ext[i];
  end

  // Baugh-Wooley rows: sign-row cross terms inverted, plus a constant 2^(WIDTH+1).
  // The sign*sign term sits at weight 2^(2*WIDTH) and falls outside the product.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar p = 0; p < PW; p++) begin : g_bit
      if (p >= i && p - i < N) begin : g_pp
        localparam bit INV = (i == N - 1) != (p - i == N - 1);
        assign rows0[i][p] = pp_q[i][p-i] ^ INV;
      end else begin : g_zero
        assign rows0[i][p] = 1'b0;
      end
    end
  end
  assign rows0[N]      = {{(PW-WIDTH-2){1'b0}}, 1'b1, {(WIDTH+1){1'b0}}};
  assign unused_pp_msb = pp_q[N-1][N-1];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int RI = rows_at_level(NROWS, l);
    localparam int RO = rows_at_level(NROWS, l + 1);
    logic [RI-1:0][PW-1:0] rows_i;
    logic [RO-1:0][PW-1:0] rows_o;
    if (l == 0) begin : g_first
      assign rows_i = rows0;
    end else begin : g_next
      assign rows_i = g_lvl[l-1].rows_o;
    end
    mayur_wallace_csa_level #(
      .ROWS_IN (RI),
      .ROWS_OUT(RO),
      .ROW_W   (PW)
    ) u_level (
      .rows_in (rows_i),
      .rows_out(rows_o)
    );
  end

  assign red_a  = g_lvl[LEVELS-1].rows_o[0];
  assign red_b  = g_lvl[LEVELS-1].rows_o[1];
  assign s3_sum = row_a_q + row_b_q;

`ifdef WALLACE_PIPE_MAC_EN
  logic acc1, acc2;
  assign s3_d = acc2 ? (s3_sum + prod_q) : s3_sum;
`else
  assign s3_d = s3_sum;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      pp_q    <= '0;
      tag1    <= '0;
      tag2    <= '0;
      tag3    <= '0;
      row_a_q <= '0;
      row_b_q <= '0;
      prod_q  <= '0;
`ifdef WALLACE_PIPE_MAC_EN
      acc1    <= 1'b0;
      acc2    <= 1'b0;
`endif
    end else begin
      if (Data_in_Ready) v1 <= Data_in_Valid;
      if (ready2)        v2 <= v1;
      if (ready3)        v3 <= v2;
      if (Data_in_Valid && Data_in_Ready) begin
        pp_q <= pp_d;
        tag1 <= Data_in_Tag;
`ifdef WALLACE_PIPE_MAC_EN
        acc1 <= Data_in_Acc;
`endif
      end
      if (v1 && ready2) begin
        row_a_q <= red_a;
        row_b_q <= red_b;
        tag2    <= tag1;
`ifdef WALLACE_PIPE_MAC_EN
        acc2    <= acc1;
`endif
      end
      if (v2 && ready3) begin
        prod_q <= s3_d;
        tag3   <= tag2;
      end
    end
  end

  assign Data_out_Prod = prod_q;
  assign Data_out_Tag  = tag3;

endmodule
